// File: rtl/gray_bin_ring_counter_if.sv
// Control and status bundle for gray_bin_ring_counter.
// The master side owns clear/count_en/count_dn; the counter (slave) returns
// the binary index, the matching gray code, the lap bit and the wrap strobe.
interface gray_bin_ring_counter_if #(
  parameter int WIDTH = 4
);

  logic             clear;
  logic             count_en;
  logic             count_dn;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             lap;
  logic             wrap_pulse;

  modport master (
    output clear,
    output count_en,
    output count_dn,
    input  bin_out,
    input  gray_out,
    input  lap,
    input  wrap_pulse
  );

  modport slave (
    input  clear,
    input  count_en,
    input  count_dn,
    output bin_out,
    output gray_out,
    output lap,
    output wrap_pulse
  );

endinterface

// File: rtl/gray_bin_ring_counter.sv
// Modulo-DEPTH up/down ring counter producing a binary index and a gray code
// that moves by exactly one bit on every step, wrap-around included. The gray
// code is taken of (index + OFFSET), which centres the used code range on the
// midpoint of the full gray sequence so both ends differ only in the MSB.
// Intended as a read/write pointer source for CDC FIFOs and line buffers.
module gray_bin_ring_counter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 10
) (
  input logic                    clock,
  input logic                    reset,
  gray_bin_ring_counter_if.slave bus
);

  localparam int OFFSET = ((1 << WIDTH) - DEPTH) / 2;
  localparam int GRAY_ORIGIN_INT = OFFSET ^ (OFFSET >> 1);

  localparam logic [WIDTH-1:0] GRAY_ORIGIN = WIDTH'(GRAY_ORIGIN_INT);
  localparam logic [WIDTH:0]   LAST_EXT    = (WIDTH + 1)'(DEPTH - 1);
  localparam logic [WIDTH:0]   OFFSET_EXT  = (WIDTH + 1)'(OFFSET);
  localparam logic [WIDTH:0]   ONE_EXT     = (WIDTH + 1)'(1);

  // Reject moduli that cannot give a symmetric, single-bit-wrap gray range.
  if ((DEPTH % 2) != 0 || DEPTH < 2 || DEPTH > (1 << WIDTH)) begin : g_bad_depth
    $fatal(1, "gray_bin_ring_counter: DEPTH must be even and within 2..2**WIDTH");
  end

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             lap_q;
  logic             wrap_q;

  logic [WIDTH:0]   bin_ext;
  logic [WIDTH:0]   next_ext;
  logic             next_lap;
  logic             next_wrap;
  logic [WIDTH:0]   offset_ext;
  logic [WIDTH:0]   gray_ext;
  logic [WIDTH-1:0] next_gray;
  logic             unused_msbs;

  assign bin_ext = {1'b0, bin_q};

  // Next index/lap/wrap, in priority order: clear, then a counting step, else hold.
  always_comb begin
    next_ext  = bin_ext;
    next_lap  = lap_q;
    next_wrap = 1'b0;
    if (bus.clear) begin
      next_ext = '0;
      next_lap = 1'b0;
    end else if (bus.count_en) begin
      if (!bus.count_dn) begin
        if (bin_ext == LAST_EXT) begin
          next_ext  = '0;
          next_lap  = ~lap_q;
          next_wrap = 1'b1;
        end else begin
          next_ext = bin_ext + ONE_EXT;
        end
      end else begin
        if (bin_ext == '0) begin
          next_ext  = LAST_EXT;
          next_lap  = ~lap_q;
          next_wrap = 1'b1;
        end else begin
          next_ext = bin_ext - ONE_EXT;
        end
      end
    end
  end

  // Gray code is derived from the next index so both outputs register together.
  assign offset_ext  = next_ext + OFFSET_EXT;
  assign gray_ext    = offset_ext ^ (offset_ext >> 1);
  assign next_gray   = gray_ext[WIDTH-1:0];
  assign unused_msbs = ^{next_ext[WIDTH], gray_ext[WIDTH]};

  // Output registers; reset drops everything to the origin immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= GRAY_ORIGIN;
      lap_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= next_ext[WIDTH-1:0];
      gray_q <= next_gray;
      lap_q  <= next_lap;
      wrap_q <= next_wrap;
    end
  end

  assign bus.bin_out    = bin_q;
  assign bus.gray_out   = gray_q;
  assign bus.lap        = lap_q;
  assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_gray_bin_ring_counter.sv
// Directed and randomised checks of gray_bin_ring_counter for DEPTH 2, 10, 16
// (all WIDTH=4). Inputs are driven on the falling edge and outputs sampled on
// the following falling edge, one rising edge later.
module tb_gray_bin_ring_counter;

  logic clock = 1'b0;
  logic reset;
  logic clear;
  logic count_en;
  logic count_dn;

  int tests_run    = 0;
  int tests_failed = 0;

  // DEPTH=10, OFFSET=3: gray(bin+3) for bin 0..9
  localparam logic [3:0] GRAY10 [10] = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                         4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010};

  always #5 clock = ~clock;

  gray_bin_ring_counter_if #(.WIDTH(4)) bus2  ();
  gray_bin_ring_counter_if #(.WIDTH(4)) bus10 ();
  gray_bin_ring_counter_if #(.WIDTH(4)) bus16 ();

  assign bus2.clear     = clear;
  assign bus2.count_en  = count_en;
  assign bus2.count_dn  = count_dn;
  assign bus10.clear    = clear;
  assign bus10.count_en = count_en;
  assign bus10.count_dn = count_dn;
  assign bus16.clear    = clear;
  assign bus16.count_en = count_en;
  assign bus16.count_dn = count_dn;

  gray_bin_ring_counter #(.WIDTH(4), .DEPTH(2))  dut2  (.clock(clock), .reset(reset), .bus(bus2));
  gray_bin_ring_counter #(.WIDTH(4), .DEPTH(10)) dut10 (.clock(clock), .reset(reset), .bus(bus10));
  gray_bin_ring_counter #(.WIDTH(4), .DEPTH(16)) dut16 (.clock(clock), .reset(reset), .bus(bus16));

  function automatic logic [3:0] gray_of(input int v);
    logic [3:0] t;
    t = v[3:0];
    return t ^ (t >> 1);
  endfunction

  // Drive one cycle of inputs at a falling edge and return at the next falling edge.
  task automatic step(input logic en, input logic dn, input logic clr);
    count_en = en;
    count_dn = dn;
    clear    = clr;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; count_en = 1'b0; count_dn = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tests_run++; if (bus10.bin_out !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset bin_out got %0d want 0", bus10.bin_out); end
    tests_run++; if (bus10.gray_out !== 4'b0010) begin tests_failed++; $display("[TB] FAIL reset gray_out got %b want 0010", bus10.gray_out); end
    tests_run++; if (bus10.lap !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset lap got %b want 0", bus10.lap); end
    tests_run++; if (bus10.wrap_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset wrap_pulse got %b want 0", bus10.wrap_pulse); end
  endtask

  task automatic test_count_up();
    for (int i = 1; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      tests_run++; if (bus10.bin_out !== i[3:0]) begin tests_failed++; $display("[TB] FAIL up bin_out got %0d want %0d", bus10.bin_out, i); end
      tests_run++; if (bus10.gray_out !== GRAY10[i]) begin tests_failed++; $display("[TB] FAIL up gray_out got %b want %b", bus10.gray_out, GRAY10[i]); end
      tests_run++; if (bus10.wrap_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL up wrap_pulse bin %0d got %b want 0", i, bus10.wrap_pulse); end
    end
    step(1'b1, 1'b0, 1'b0);
    tests_run++; if (bus10.bin_out !== 4'd0) begin tests_failed++; $display("[TB] FAIL up_wrap bin_out got %0d want 0", bus10.bin_out); end
    tests_run++; if (bus10.gray_out !== 4'b0010) begin tests_failed++; $display("[TB] FAIL up_wrap gray_out got %b want 0010", bus10.gray_out); end
    tests_run++; if (bus10.lap !== 1'b1) begin tests_failed++; $display("[TB] FAIL up_wrap lap got %b want 1", bus10.lap); end
    tests_run++; if (bus10.wrap_pulse !== 1'b1) begin tests_failed++; $display("[TB] FAIL up_wrap wrap_pulse got %b want 1", bus10.wrap_pulse); end
    step(1'b1, 1'b0, 1'b0);
    tests_run++; if (bus10.bin_out !== 4'd1) begin tests_failed++; $display("[TB] FAIL up_after bin_out got %0d want 1", bus10.bin_out); end
    tests_run++; if (bus10.gray_out !== 4'b0110) begin tests_failed++; $display("[TB] FAIL up_after gray_out got %b want 0110", bus10.gray_out); end
    tests_run++; if (bus10.wrap_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL up_after wrap_pulse got %b want 0", bus10.wrap_pulse); end
    tests_run++; if (bus10.lap !== 1'b1) begin tests_failed++; $display("[TB] FAIL up_after lap got %b want 1", bus10.lap); end
  endtask

  task automatic test_count_down();
    step(1'b0, 1'b0, 1'b1);
    tests_run++; if (bus10.lap !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear lap got %b want 0", bus10.lap); end
    step(1'b1, 1'b1, 1'b0);
    tests_run++; if (bus10.bin_out !== 4'd9) begin tests_failed++; $display("[TB] FAIL dn_wrap bin_out got %0d want 9", bus10.bin_out); end
    tests_run++; if (bus10.gray_out !== 4'b1010) begin tests_failed++; $display("[TB] FAIL dn_wrap gray_out got %b want 1010", bus10.gray_out); end
    tests_run++; if (bus10.lap !== 1'b1) begin tests_failed++; $display("[TB] FAIL dn_wrap lap got %b want 1", bus10.lap); end
    tests_run++; if (bus10.wrap_pulse !== 1'b1) begin tests_failed++; $display("[TB] FAIL dn_wrap wrap_pulse got %b want 1", bus10.wrap_pulse); end
    step(1'b1, 1'b1, 1'b0);
    tests_run++; if (bus10.bin_out !== 4'd8) begin tests_failed++; $display("[TB] FAIL dn_after bin_out got %0d want 8", bus10.bin_out); end
    tests_run++; if (bus10.gray_out !== 4'b1110) begin tests_failed++; $display("[TB] FAIL dn_after gray_out got %b want 1110", bus10.gray_out); end
    tests_run++; if (bus10.wrap_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL dn_after wrap_pulse got %b want 0", bus10.wrap_pulse); end
  endtask

  task automatic test_clear_hold();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    tests_run++; if (bus10.bin_out !== 4'd5 || bus10.lap !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_clear bin/lap got %0d/%b want 5/1", bus10.bin_out, bus10.lap); end
    step(1'b1, 1'b0, 1'b1);
    tests_run++; if (bus10.bin_out !== 4'd0) begin tests_failed++; $display("[TB] FAIL clear_en bin_out got %0d want 0", bus10.bin_out); end
    tests_run++; if (bus10.gray_out !== 4'b0010) begin tests_failed++; $display("[TB] FAIL clear_en gray_out got %b want 0010", bus10.gray_out); end
    tests_run++; if (bus10.lap !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_en lap got %b want 0", bus10.lap); end
    tests_run++; if (bus10.wrap_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_en wrap_pulse got %b want 0", bus10.wrap_pulse); end
    repeat (5) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, i[0], 1'b0);
      tests_run++; if (bus10.bin_out !== 4'd5) begin tests_failed++; $display("[TB] FAIL hold bin_out got %0d want 5", bus10.bin_out); end
      tests_run++; if (bus10.gray_out !== 4'b1100) begin tests_failed++; $display("[TB] FAIL hold gray_out got %b want 1100", bus10.gray_out); end
      tests_run++; if (bus10.lap !== 1'b0 || bus10.wrap_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold lap/wrap got %b/%b want 0/0", bus10.lap, bus10.wrap_pulse); end
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    tests_run++; if (bus10.wrap_pulse !== 1'b1 || bus10.bin_out !== 4'd9) begin tests_failed++; $display("[TB] FAIL b2b_first wrap/bin got %b/%0d want 1/9", bus10.wrap_pulse, bus10.bin_out); end
    step(1'b1, 1'b0, 1'b0);
    tests_run++; if (bus10.wrap_pulse !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_second wrap_pulse got %b want 1", bus10.wrap_pulse); end
    tests_run++; if (bus10.bin_out !== 4'd0 || bus10.gray_out !== 4'b0010) begin tests_failed++; $display("[TB] FAIL b2b_second bin/gray got %0d/%b want 0/0010", bus10.bin_out, bus10.gray_out); end
    tests_run++; if (bus10.lap !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_second lap got %b want 0", bus10.lap); end
    step(1'b0, 1'b0, 1'b0);
    tests_run++; if (bus10.wrap_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle wrap_pulse got %b want 0", bus10.wrap_pulse); end
  endtask

  task automatic test_random();
    int         depth [3];
    int         offs  [3];
    int         mbin  [3];
    logic       mlap  [3];
    logic       mwrap [3];
    logic [3:0] prevg [3];
    logic [3:0] ob    [3];
    logic [3:0] og    [3];
    logic       ol    [3];
    logic       ow    [3];
    logic       en;
    logic       dn;
    depth = '{2, 10, 16};
    offs  = '{7, 3, 0};
    step(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      mbin[k] = 0; mlap[k] = 1'b0; prevg[k] = gray_of(offs[k]);
    end
    for (int c = 0; c < 2000; c++) begin
      en = ($urandom_range(0, 3) != 0);
      dn = $urandom_range(0, 1) == 1;
      step(en, dn, 1'b0);
      ob = '{bus2.bin_out, bus10.bin_out, bus16.bin_out};
      og = '{bus2.gray_out, bus10.gray_out, bus16.gray_out};
      ol = '{bus2.lap, bus10.lap, bus16.lap};
      ow = '{bus2.wrap_pulse, bus10.wrap_pulse, bus16.wrap_pulse};
      for (int k = 0; k < 3; k++) begin
        mwrap[k] = 1'b0;
        if (en) begin
          if (!dn) begin
            if (mbin[k] == depth[k] - 1) begin mbin[k] = 0; mlap[k] = ~mlap[k]; mwrap[k] = 1'b1; end
            else mbin[k] = mbin[k] + 1;
          end else begin
            if (mbin[k] == 0) begin mbin[k] = depth[k] - 1; mlap[k] = ~mlap[k]; mwrap[k] = 1'b1; end
            else mbin[k] = mbin[k] - 1;
          end
        end
        tests_run++; if (ob[k] !== mbin[k][3:0]) begin tests_failed++; $display("[TB] FAIL rand D%0d cyc %0d bin_out got %0d want %0d", depth[k], c, ob[k], mbin[k]); end
        tests_run++; if (og[k] !== gray_of(mbin[k] + offs[k])) begin tests_failed++; $display("[TB] FAIL rand D%0d cyc %0d gray_out got %b want %b", depth[k], c, og[k], gray_of(mbin[k] + offs[k])); end
        tests_run++; if ($countones(og[k] ^ prevg[k]) != (en ? 1 : 0)) begin tests_failed++; $display("[TB] FAIL rand D%0d cyc %0d gray bits changed got %0d want %0d", depth[k], c, $countones(og[k] ^ prevg[k]), en ? 1 : 0); end
        tests_run++; if (ol[k] !== mlap[k]) begin tests_failed++; $display("[TB] FAIL rand D%0d cyc %0d lap got %b want %b", depth[k], c, ol[k], mlap[k]); end
        tests_run++; if (ow[k] !== mwrap[k]) begin tests_failed++; $display("[TB] FAIL rand D%0d cyc %0d wrap_pulse got %b want %b", depth[k], c, ow[k], mwrap[k]); end
        prevg[k] = og[k];
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    tests_run++; if (bus10.bin_out !== 4'd7 || bus10.lap !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_areset bin/lap got %0d/%b want 7/1", bus10.bin_out, bus10.lap); end
    count_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests_run++; if (bus10.bin_out !== 4'd0) begin tests_failed++; $display("[TB] FAIL areset bin_out got %0d want 0", bus10.bin_out); end
    tests_run++; if (bus10.gray_out !== 4'b0010) begin tests_failed++; $display("[TB] FAIL areset gray_out got %b want 0010", bus10.gray_out); end
    tests_run++; if (bus10.lap !== 1'b0 || bus10.wrap_pulse !== 1'b0) begin tests_failed++; $display("[TB] FAIL areset lap/wrap got %b/%b want 0/0", bus10.lap, bus10.wrap_pulse); end
    count_en = 1'b1;
    @(negedge clock);
    tests_run++; if (bus10.bin_out !== 4'd0) begin tests_failed++; $display("[TB] FAIL areset_held bin_out got %0d want 0", bus10.bin_out); end
    reset = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    tests_run++; if (bus10.bin_out !== 4'd1 || bus10.gray_out !== 4'b0110) begin tests_failed++; $display("[TB] FAIL areset_resume bin/gray got %0d/%b want 1/0110", bus10.bin_out, bus10.gray_out); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_clear_hold();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
